// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared encodings for the RV32 execute stage.
// Holds the aluop/alusel codes, reset level, the zero constants and
// the divider state encoding.
package ex_stage_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam logic              RstEnable  = 1'b0;
   localparam logic [DATA_W-1:0] ZeroWord   = '0;
   localparam logic [REG_AW-1:0] NOPRegAddr = '0;

   // result classes
   localparam logic [2:0] SEL_NOP    = 3'd0;
   localparam logic [2:0] SEL_LOGIC  = 3'd1;
   localparam logic [2:0] SEL_SHIFT  = 3'd2;
   localparam logic [2:0] SEL_ARITH  = 3'd3;
   localparam logic [2:0] SEL_BRANCH = 3'd4;
   localparam logic [2:0] SEL_JUMP   = 3'd5;
   localparam logic [2:0] SEL_MULDIV = 3'd6;

   // operation codes
   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_AND    = 8'h01;
   localparam logic [7:0] OP_OR     = 8'h02;
   localparam logic [7:0] OP_XOR    = 8'h03;
   localparam logic [7:0] OP_SLL    = 8'h04;
   localparam logic [7:0] OP_SRL    = 8'h05;
   localparam logic [7:0] OP_SRA    = 8'h06;
   localparam logic [7:0] OP_ADD    = 8'h07;
   localparam logic [7:0] OP_SUB    = 8'h08;
   localparam logic [7:0] OP_SLT    = 8'h09;
   localparam logic [7:0] OP_SLTU   = 8'h0A;
   localparam logic [7:0] OP_BEQ    = 8'h10;
   localparam logic [7:0] OP_BNE    = 8'h11;
   localparam logic [7:0] OP_BLT    = 8'h12;
   localparam logic [7:0] OP_BGE    = 8'h13;
   localparam logic [7:0] OP_BLTU   = 8'h14;
   localparam logic [7:0] OP_BGEU   = 8'h15;
   localparam logic [7:0] OP_JAL    = 8'h16;
   localparam logic [7:0] OP_JALR   = 8'h17;
   localparam logic [7:0] OP_MUL    = 8'h18;
   localparam logic [7:0] OP_MULH   = 8'h19;
   localparam logic [7:0] OP_MULHSU = 8'h1A;
   localparam logic [7:0] OP_MULHU  = 8'h1B;
   localparam logic [7:0] OP_DIV    = 8'h1C;
   localparam logic [7:0] OP_DIVU   = 8'h1D;
   localparam logic [7:0] OP_REM    = 8'h1E;
   localparam logic [7:0] OP_REMU   = 8'h1F;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX bundle in, EX/MEM bundle plus redirect/stall out.
// Handshake: the ID/EX contents are consumed on a rising edge where
// stall_req_o is 0; while stall_req_o is 1 the upstream holds the bundle
// and the outputs carry no valid result (wreg_o = 0).
interface ex_stage_if;
   import ex_stage_pkg::*;

   logic [7:0]        ex_aluop;
   logic [2:0]        ex_alusel;
   logic [DATA_W-1:0] ex_reg1;
   logic [DATA_W-1:0] ex_reg2;
   logic [REG_AW-1:0] ex_wd;
   logic              ex_wreg;
   logic [DATA_W-1:0] ex_link_pc;
   logic [DATA_W-1:0] ex_branch_offset;

   logic [REG_AW-1:0] wd_o;
   logic              wreg_o;
   logic [DATA_W-1:0] wdata_o;
   logic              branch_flag_o;
   logic [DATA_W-1:0] branch_target_o;
   logic              stall_req_o;
   div_state_t        div_state;

   modport master (
      output ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
             ex_link_pc, ex_branch_offset,
      input  wd_o, wreg_o, wdata_o, branch_flag_o, branch_target_o,
             stall_req_o, div_state
   );

   modport slave (
      input  ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
             ex_link_pc, ex_branch_offset,
      output wd_o, wreg_o, wdata_o, branch_flag_o, branch_target_o,
             stall_req_o, div_state
   );

endinterface

// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring divider on magnitudes, one step per cycle.
// IDLE -> BUSY (DIV_ITERS steps) -> DONE (one cycle, signed result shown).
module ex_divider
   import ex_stage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DIV_ITERS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              start,
   input  logic [XLEN-1:0]   dividend,
   input  logic [XLEN-1:0]   divisor,
   input  logic              neg_quot,
   input  logic              neg_rem,
   input  logic              is_rem,
   input  logic [REG_AW-1:0] wd,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   quotient,
   output logic [XLEN-1:0]   remainder,
   output logic              rem_sel,
   output logic [REG_AW-1:0] wd_q,
   output div_state_t        state
);

   localparam int            CW   = $clog2(DIV_ITERS);
   localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

   div_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] quo_q, rem_q, dvs_q;
   logic            neg_quot_q, neg_rem_q;
   logic [XLEN:0]   shifted, diff;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) state_q <= DIV_IDLE;
      else                  state_q <= state_d;
   end

   // next state; a flush always returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: if (start) state_d = DIV_BUSY;
         DIV_BUSY: if (cnt_q == LAST) state_d = DIV_DONE;
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
      if (flush) state_d = DIV_IDLE;
   end

   // trial subtraction of the divisor from the shifted partial remainder
   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs_q};

   // operand latch on start, then one restoring step per BUSY cycle
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         cnt_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         rem_sel    <= 1'b0;
         wd_q       <= NOPRegAddr;
      end else if (state_q == DIV_IDLE && start && !flush) begin
         cnt_q      <= '0;
         quo_q      <= dividend;
         rem_q      <= '0;
         dvs_q      <= divisor;
         neg_quot_q <= neg_quot;
         neg_rem_q  <= neg_rem;
         rem_sel    <= is_rem;
         wd_q       <= wd;
      end else if (state_q == DIV_BUSY) begin
         cnt_q <= cnt_q + 1'b1;
         quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
         rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      end
   end

   assign busy      = (state_q == DIV_BUSY);
   assign done      = (state_q == DIV_DONE);
   assign state     = state_q;
   assign quotient  = neg_quot_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q  ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage. Combinational ALU/shift/branch/jump,
// iterative DIV/DIVU/REM/REMU through ex_divider with upstream stall.
// Optional macro EX_MUL_EN enables single-cycle MUL/MULH/MULHSU/MULHU.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int XLEN      = DATA_W,
   parameter int DIV_ITERS = DATA_W
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush_i,
   ex_stage_if.slave bus
);

   logic [XLEN-1:0]   reg1, reg2, sc_wdata, sc_target, link_m4, jalr_sum;
   logic [XLEN-1:0]   abs1, abs2, div_quot, div_remd;
   logic [4:0]        shamt;
   logic              sc_wreg, sc_flag, take;
   logic              div_op, div_signed, div_rem, div_by_zero, div_ovf, div_start;
   logic              div_busy, div_done, div_rem_sel;
   logic [REG_AW-1:0] div_wd;
   div_state_t        div_state;

   assign reg1     = bus.ex_reg1;
   assign reg2     = bus.ex_reg2;
   assign shamt    = reg2[4:0];
   assign link_m4  = bus.ex_link_pc - XLEN'(4) + bus.ex_branch_offset;
   assign jalr_sum = reg1 + bus.ex_branch_offset;

   assign div_op      = (bus.ex_alusel == SEL_MULDIV) && is_div_op(bus.ex_aluop);
   assign div_signed  = (bus.ex_aluop == OP_DIV) || (bus.ex_aluop == OP_REM);
   assign div_rem     = (bus.ex_aluop == OP_REM) || (bus.ex_aluop == OP_REMU);
   assign div_by_zero = (reg2 == '0);
   assign div_ovf     = div_signed && (reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (reg2 == '1);
   // special cases finish combinationally; a flush blocks any new start
   assign div_start   = div_op && !div_by_zero && !div_ovf && !flush_i
                        && (div_state == DIV_IDLE);
   assign abs1        = (div_signed && reg1[XLEN-1]) ? -reg1 : reg1;
   assign abs2        = (div_signed && reg2[XLEN-1]) ? -reg2 : reg2;

`ifdef EX_MUL_EN
   logic signed [XLEN:0]     mul_a, mul_b;
   logic signed [2*XLEN+1:0] mul_p;
   logic                     mul_op;
   assign mul_op = (bus.ex_aluop == OP_MUL) || (bus.ex_aluop == OP_MULH)
                   || (bus.ex_aluop == OP_MULHSU) || (bus.ex_aluop == OP_MULHU);
   assign mul_a  = {((bus.ex_aluop == OP_MULH) || (bus.ex_aluop == OP_MULHSU)) & reg1[XLEN-1], reg1};
   assign mul_b  = {(bus.ex_aluop == OP_MULH) & reg2[XLEN-1], reg2};
   assign mul_p  = mul_a * mul_b;
`endif

   ex_divider #(.XLEN(XLEN), .DIV_ITERS(DIV_ITERS)) u_div (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .start     (div_start),
      .dividend  (abs1),
      .divisor   (abs2),
      .neg_quot  (div_signed && (reg1[XLEN-1] ^ reg2[XLEN-1])),
      .neg_rem   (div_signed && reg1[XLEN-1]),
      .is_rem    (div_rem),
      .wd        (bus.ex_wd),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quot),
      .remainder (div_remd),
      .rem_sel   (div_rem_sel),
      .wd_q      (div_wd),
      .state     (div_state)
   );

   // single-cycle result, redirect and write enable from the ID/EX bundle
   always_comb begin
      sc_wdata  = ZeroWord;
      sc_wreg   = bus.ex_wreg;
      sc_flag   = 1'b0;
      sc_target = ZeroWord;
      take      = 1'b0;
      case (bus.ex_alusel)
         SEL_LOGIC: begin
            case (bus.ex_aluop)
               OP_AND:  sc_wdata = reg1 & reg2;
               OP_OR:   sc_wdata = reg1 | reg2;
               OP_XOR:  sc_wdata = reg1 ^ reg2;
               default: sc_wdata = ZeroWord;
            endcase
         end
         SEL_SHIFT: begin
            case (bus.ex_aluop)
               OP_SLL:  sc_wdata = reg1 << shamt;
               OP_SRL:  sc_wdata = reg1 >> shamt;
               OP_SRA:  sc_wdata = $signed(reg1) >>> shamt;
               default: sc_wdata = ZeroWord;
            endcase
         end
         SEL_ARITH: begin
            case (bus.ex_aluop)
               OP_ADD:  sc_wdata = reg1 + reg2;
               OP_SUB:  sc_wdata = reg1 - reg2;
               OP_SLT:  sc_wdata = {{(XLEN-1){1'b0}}, ($signed(reg1) < $signed(reg2))};
               OP_SLTU: sc_wdata = {{(XLEN-1){1'b0}}, (reg1 < reg2)};
               default: sc_wdata = ZeroWord;
            endcase
         end
         SEL_BRANCH: begin
            sc_wreg = 1'b0;
            case (bus.ex_aluop)
               OP_BEQ:  take = (reg1 == reg2);
               OP_BNE:  take = (reg1 != reg2);
               OP_BLT:  take = ($signed(reg1) < $signed(reg2));
               OP_BGE:  take = ($signed(reg1) >= $signed(reg2));
               OP_BLTU: take = (reg1 < reg2);
               OP_BGEU: take = (reg1 >= reg2);
               default: take = 1'b0;
            endcase
            sc_flag   = take;
            sc_target = link_m4;
         end
         SEL_JUMP: begin
            sc_wdata = bus.ex_link_pc;
            if (bus.ex_aluop == OP_JAL) begin
               sc_flag   = 1'b1;
               sc_target = link_m4;
            end else if (bus.ex_aluop == OP_JALR) begin
               sc_flag   = 1'b1;
               sc_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
         end
         SEL_MULDIV: begin
            sc_wreg = 1'b0;
            if (div_op && div_by_zero) begin
               sc_wreg  = bus.ex_wreg;
               sc_wdata = div_rem ? reg1 : '1;
            end else if (div_op && div_ovf) begin
               sc_wreg  = bus.ex_wreg;
               sc_wdata = div_rem ? ZeroWord : {1'b1, {(XLEN-1){1'b0}}};
            end
`ifdef EX_MUL_EN
            if (mul_op) begin
               sc_wreg  = bus.ex_wreg;
               sc_wdata = (bus.ex_aluop == OP_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
            end
`endif
         end
         default: sc_wreg = 1'b0;
      endcase
      if (bus.ex_aluop == OP_NOP) begin
         sc_wreg  = 1'b0;
         sc_wdata = ZeroWord;
         sc_flag  = 1'b0;
      end
   end

   // output select: reset, divide result, divide in progress, or single-cycle
   always_comb begin
      bus.wd_o            = NOPRegAddr;
      bus.wreg_o          = 1'b0;
      bus.wdata_o         = ZeroWord;
      bus.branch_flag_o   = 1'b0;
      bus.branch_target_o = ZeroWord;
      bus.stall_req_o     = 1'b0;
      if (rst != RstEnable) begin
         if (div_done) begin
            if (!flush_i) begin
               bus.wd_o    = div_wd;
               bus.wreg_o  = 1'b1;
               bus.wdata_o = div_rem_sel ? div_remd : div_quot;
            end
         end else if (div_busy) begin
            bus.stall_req_o = !flush_i;
         end else begin
            bus.wd_o            = bus.ex_wd;
            bus.wreg_o          = sc_wreg && !flush_i && !div_start;
            bus.wdata_o         = sc_wdata;
            bus.branch_flag_o   = sc_flag;
            bus.branch_target_o = sc_target;
            bus.stall_req_o     = div_start;
         end
      end
   end

   assign bus.div_state = div_state;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage with a queue-based scoreboard.
module tb_ex_stage;
   import ex_stage_pkg::*;

   typedef struct packed {
      logic [7:0]  id;
      logic [7:0]  stalls;
      logic        chk_data;
      logic        flag;
      logic [31:0] target;
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
   } exp_t;

   localparam int EXP_W = $bits(exp_t);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush_i = 1'b0;
   logic mon_en = 1'b0;
   logic [EXP_W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;

   ex_stage_if bus ();

   ex_stage dut (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .bus     (bus.slave)
   );

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
      end
   endtask

   task automatic push(input int id, input int stalls, input logic cd, input logic fl,
                       input logic [31:0] tgt, input logic wr, input logic [4:0] wd,
                       input logic [31:0] wdata);
      exp_t e;
      e.id       = 8'(id);
      e.stalls   = 8'(stalls);
      e.chk_data = cd;
      e.flag     = fl;
      e.target   = tgt;
      e.wreg     = wr;
      e.wd       = wd;
      e.wdata    = wdata;
      exp_q.push_back(e);
   endtask

   task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                         input logic [31:0] link, input logic [31:0] off);
      bus.ex_aluop         = op;
      bus.ex_alusel        = sel;
      bus.ex_reg1          = r1;
      bus.ex_reg2          = r2;
      bus.ex_wd            = wd;
      bus.ex_wreg          = wr;
      bus.ex_link_pc       = link;
      bus.ex_branch_offset = off;
   endtask

   // drive one instruction and hold it until the stage consumes it
   task automatic run(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                      input logic [31:0] link, input logic [31:0] off);
      int n;
      set_in(op, sel, r1, r2, wd, wr, link, off);
      n = 0;
      forever begin
         @(negedge clk);
         if (!bus.stall_req_o) break;
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: stall_req_o still 1 after %0d cycles, expected release", n);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // monitor: count stall cycles, then pop and compare on each output cycle
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && rst) begin
         if (bus.stall_req_o) begin
            stall_cnt++;
            chk(0, "wreg_during_stall", 32'(bus.wreg_o), 32'd0);
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: wreg_o=%b wdata_o=0x%08h, expected no output",
                     bus.wreg_o, bus.wdata_o);
         end else begin
            e = exp_q.pop_front();
            chk(int'(e.id), "stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            chk(int'(e.id), "wreg_o", 32'(bus.wreg_o), 32'(e.wreg));
            chk(int'(e.id), "branch_flag_o", 32'(bus.branch_flag_o), 32'(e.flag));
            if (e.flag) chk(int'(e.id), "branch_target_o", bus.branch_target_o, e.target);
            if (e.wreg) chk(int'(e.id), "wd_o", 32'(bus.wd_o), 32'(e.wd));
            if (e.chk_data) chk(int'(e.id), "wdata_o", bus.wdata_o, e.wdata);
            stall_cnt = 0;
         end
      end
   end

   // stimulus
   initial begin
      set_in(OP_ADD, SEL_ARITH, 32'h1, 32'h1, 5'd9, 1'b1, 0, 0);
      #3;
      chk(100, "reset_wreg_o", 32'(bus.wreg_o), 32'd0);
      chk(100, "reset_wd_o", 32'(bus.wd_o), 32'd0);
      chk(100, "reset_wdata_o", bus.wdata_o, 32'd0);
      chk(100, "reset_branch_flag_o", 32'(bus.branch_flag_o), 32'd0);
      chk(100, "reset_stall_req_o", 32'(bus.stall_req_o), 32'd0);
      chk(100, "reset_div_state", 32'(bus.div_state), 32'(DIV_IDLE));
      set_in(OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      push(1, 0, 1'b1, 1'b0, 0, 1'b1, 5'd5, 32'h8000_0000);
      run(OP_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 0, 0);
      push(2, 0, 1'b0, 1'b1, 32'h120, 1'b0, 5'd7, 0);
      run(OP_BLT, SEL_BRANCH, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1, 32'h104, 32'h20);
      push(3, 0, 1'b0, 1'b0, 0, 1'b0, 5'd7, 0);
      run(OP_BLTU, SEL_BRANCH, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1, 32'h104, 32'h20);
      push(4, 0, 1'b1, 1'b0, 0, 1'b1, 5'd6, 32'h1);
      run(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b1, 0, 0);
      push(5, 0, 1'b1, 1'b0, 0, 1'b1, 5'd6, 32'h0);
      run(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b1, 0, 0);
      push(6, 0, 1'b1, 1'b0, 0, 1'b1, 5'd8, 32'hC000_0000);
      run(OP_SRA, SEL_SHIFT, 32'h8000_0000, 32'h21, 5'd8, 1'b1, 0, 0);
      push(7, 0, 1'b1, 1'b0, 0, 1'b1, 5'd8, 32'h4000_0000);
      run(OP_SRL, SEL_SHIFT, 32'h8000_0000, 32'h21, 5'd8, 1'b1, 0, 0);
      push(8, 0, 1'b1, 1'b0, 0, 1'b1, 5'd8, 32'h8000_0000);
      run(OP_SLL, SEL_SHIFT, 32'h1, 32'h1F, 5'd8, 1'b1, 0, 0);
      push(9, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'hFFFF_FFFF);
      run(OP_SUB, SEL_ARITH, 32'h0, 32'h1, 5'd2, 1'b1, 0, 0);
      push(10, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'h0FF0_0FF0);
      run(OP_XOR, SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 1'b1, 0, 0);
      push(11, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'hF000_F000);
      run(OP_AND, SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 1'b1, 0, 0);
      push(12, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'hFFF0_FFF0);
      run(OP_OR, SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 1'b1, 0, 0);
      push(13, 0, 1'b1, 1'b1, 32'h2FC, 1'b1, 5'd1, 32'h200);
      run(OP_JAL, SEL_JUMP, 0, 0, 5'd1, 1'b1, 32'h200, 32'h100);
      push(14, 0, 1'b1, 1'b1, 32'h1010, 1'b1, 5'd1, 32'h300);
      run(OP_JALR, SEL_JUMP, 32'h1001, 0, 5'd1, 1'b1, 32'h300, 32'h10);
      push(15, 0, 1'b0, 1'b1, 32'h4, 1'b0, 5'd0, 0);
      run(OP_BEQ, SEL_BRANCH, 32'h5, 32'h5, 5'd0, 1'b0, 32'h10, 32'hFFFF_FFF8);
      push(16, 0, 1'b0, 1'b0, 0, 1'b0, 5'd0, 0);
      run(OP_BNE, SEL_BRANCH, 32'h5, 32'h5, 5'd0, 1'b0, 32'h10, 32'hFFFF_FFF8);
      push(17, 0, 1'b0, 1'b1, 32'h44, 1'b0, 5'd0, 0);
      run(OP_BGE, SEL_BRANCH, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h40, 32'h8);
      push(18, 0, 1'b0, 1'b0, 0, 1'b0, 5'd0, 0);
      run(OP_BGEU, SEL_BRANCH, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h40, 32'h8);

      push(19, 33, 1'b1, 1'b0, 0, 1'b1, 5'd3, 32'hFFFF_FFFD);
      run(OP_DIV, SEL_MULDIV, 32'hFFFF_FFF9, 32'h2, 5'd3, 1'b1, 0, 0);
      push(20, 33, 1'b1, 1'b0, 0, 1'b1, 5'd3, 32'hFFFF_FFFF);
      run(OP_REM, SEL_MULDIV, 32'hFFFF_FFF9, 32'h2, 5'd3, 1'b1, 0, 0);
      push(21, 33, 1'b1, 1'b0, 0, 1'b1, 5'd3, 32'hFFFF_FFF2);
      run(OP_DIV, SEL_MULDIV, 32'd100, 32'hFFFF_FFF9, 5'd3, 1'b1, 0, 0);
      push(22, 33, 1'b1, 1'b0, 0, 1'b1, 5'd3, 32'h2);
      run(OP_REM, SEL_MULDIV, 32'd100, 32'hFFFF_FFF9, 5'd3, 1'b1, 0, 0);
      push(23, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'hFFFF_FFFF);
      run(OP_DIVU, SEL_MULDIV, 32'h1234, 32'h0, 5'd2, 1'b1, 0, 0);
      push(24, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'h5);
      run(OP_REMU, SEL_MULDIV, 32'h5, 32'h0, 5'd2, 1'b1, 0, 0);
      push(25, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'h8000_0000);
      run(OP_DIV, SEL_MULDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b1, 0, 0);
      push(26, 0, 1'b1, 1'b0, 0, 1'b1, 5'd2, 32'h0);
      run(OP_REM, SEL_MULDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b1, 0, 0);
`ifdef EX_MUL_EN
      push(27, 0, 1'b1, 1'b0, 0, 1'b1, 5'd9, 32'd12);
`else
      push(27, 0, 1'b1, 1'b0, 0, 1'b0, 5'd9, 32'd0);
`endif
      run(OP_MUL, SEL_MULDIV, 32'd3, 32'd4, 5'd9, 1'b1, 0, 0);
      push(28, 0, 1'b1, 1'b0, 0, 1'b0, 5'd9, 32'd0);
      run(OP_NOP, SEL_NOP, 32'h123, 32'h456, 5'd9, 1'b1, 0, 0);
      push(29, 0, 1'b1, 1'b0, 0, 1'b1, 5'd0, 32'd5);
      run(OP_ADD, SEL_ARITH, 32'd2, 32'd3, 5'd0, 1'b1, 0, 0);

      // flush in the tenth BUSY cycle: ten stall cycles, then a silent cycle
      push(30, 10, 1'b1, 1'b0, 0, 1'b0, 5'd0, 32'd0);
      set_in(OP_DIVU, SEL_MULDIV, 32'd100, 32'd7, 5'd4, 1'b1, 0, 0);
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1;
      set_in(OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      chk(30, "flush_div_state", 32'(bus.div_state), 32'(DIV_IDLE));
      push(31, 33, 1'b1, 1'b0, 0, 1'b1, 5'd4, 32'd14);
      run(OP_DIVU, SEL_MULDIV, 32'd100, 32'd7, 5'd4, 1'b1, 0, 0);
      push(32, 33, 1'b1, 1'b0, 0, 1'b1, 5'd4, 32'd2);
      run(OP_REMU, SEL_MULDIV, 32'd100, 32'd7, 5'd4, 1'b1, 0, 0);

      // asynchronous reset in the middle of a divide
      mon_en = 1'b0;
      set_in(OP_DIVU, SEL_MULDIV, 32'd100, 32'd7, 5'd4, 1'b1, 0, 0);
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk(33, "midreset_wreg_o", 32'(bus.wreg_o), 32'd0);
      chk(33, "midreset_wd_o", 32'(bus.wd_o), 32'd0);
      chk(33, "midreset_wdata_o", bus.wdata_o, 32'd0);
      chk(33, "midreset_branch_flag_o", 32'(bus.branch_flag_o), 32'd0);
      chk(33, "midreset_stall_req_o", 32'(bus.stall_req_o), 32'd0);
      chk(33, "midreset_div_state", 32'(bus.div_state), 32'(DIV_IDLE));
      set_in(OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      push(34, 0, 1'b1, 1'b0, 0, 1'b1, 5'd11, 32'h1E);
      run(OP_ADD, SEL_ARITH, 32'd10, 32'd20, 5'd11, 1'b1, 0, 0);
      push(35, 0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 32'd0);
      run(OP_NOP, SEL_NOP, 0, 0, 5'd0, 1'b0, 0, 0);

      mon_en = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
